// File: rtl/rip_type.sv
// Shared decode-stage types: opcode/funct7 constants, the one-hot
// instruction record, the decoded packet and the handshake state.
package rip_type;

    localparam int XLEN   = 32;
    localparam int REG_AW = 5;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

    // funct7 values accepted on OP / shift-immediate encodings
    localparam logic [6:0] F7_BASE   = 7'h00;
    localparam logic [6:0] F7_ALT    = 7'h20;  // SUB, SRA, SRAI
    localparam logic [6:0] F7_MULDIV = 7'h01;  // M extension

    // Exact SYSTEM encodings without a CSR
    localparam logic [31:0] ENC_ECALL  = 32'h0000_0073;
    localparam logic [31:0] ENC_EBREAK = 32'h0010_0073;

    // One flag per instruction, MSB first in this order.
    typedef struct packed {
        logic lui, auipc, jal, jalr;
        logic beq, bne, blt, bge, bltu, bgeu;
        logic lb, lh, lw, lbu, lhu;
        logic sb, sh, sw;
        logic addi, slti, sltiu, xori, ori, andi, slli, srli, srai;
        logic add, sub, sll, slt, sltu, xor_op, srl, sra, or_op, and_op;
        logic mul, mulh, mulhsu, mulhu, div, divu, rem, remu;
        logic csrrw, csrrs, csrrc, csrrwi, csrrsi, csrrci;
        logic ecall, ebreak;
    } inst_t;

    typedef struct packed {
        inst_t              inst;
        logic [REG_AW-1:0]  rs1_addr;
        logic [REG_AW-1:0]  rs2_addr;
        logic [REG_AW-1:0]  rd_addr;
        logic [XLEN-1:0]    imm;
        logic [4:0]         zimm;
        logic [11:0]        csr_addr;
        logic [XLEN-1:0]    pc;
        logic               illegal;
    } dec_pkt_t;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } state_e;

endpackage

// File: rtl/rip_imm_gen.sv
// Combinational immediate formatter; the format is chosen from the opcode.
module rip_imm_gen
    import rip_type::*;
(
    input  logic [XLEN-1:0] i_inst,
    output logic [XLEN-1:0] o_imm
);

    // Pick the immediate layout for the instruction format; R-type, SYSTEM
    // and unknown opcodes produce zero.
    always_comb begin
        o_imm = '0;
        case (i_inst[6:0])
            OPC_LOAD, OPC_OP_IMM, OPC_JALR:
                o_imm = {{20{i_inst[31]}}, i_inst[31:20]};
            OPC_STORE:
                o_imm = {{20{i_inst[31]}}, i_inst[31:25], i_inst[11:7]};
            OPC_BRANCH:
                o_imm = {{19{i_inst[31]}}, i_inst[31], i_inst[7], i_inst[30:25],
                         i_inst[11:8], 1'b0};
            OPC_LUI, OPC_AUIPC:
                o_imm = {i_inst[31:12], 12'b0};
            OPC_JAL:
                o_imm = {{11{i_inst[31]}}, i_inst[31], i_inst[19:12], i_inst[20],
                         i_inst[30:21], 1'b0};
            default:
                o_imm = '0;
        endcase
    end

endmodule

// File: rtl/rip_decode_stage.sv
// RV32IM+Zicsr decode stage with valid/ready on both sides and a two-entry
// (main + skid) buffer so in_ready depends only on registered state.
// Only the default DATA_WIDTH/REG_ADDR_WIDTH values are meaningful.
module rip_decode_stage
    import rip_type::*;
#(
    parameter int DATA_WIDTH     = 32,
    parameter int REG_ADDR_WIDTH = 5
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      flush,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [DATA_WIDTH-1:0]     in_inst,
    input  logic [DATA_WIDTH-1:0]     in_pc,
    output logic                      out_valid,
    input  logic                      out_ready,
    output inst_t                     out_inst,
    output logic [REG_ADDR_WIDTH-1:0] out_rs1_addr,
    output logic [REG_ADDR_WIDTH-1:0] out_rs2_addr,
    output logic [REG_ADDR_WIDTH-1:0] out_rd_addr,
    output logic [DATA_WIDTH-1:0]     out_imm,
    output logic [4:0]                out_zimm,
    output logic [11:0]               out_csr_addr,
    output logic [DATA_WIDTH-1:0]     out_pc,
    output logic                      out_illegal
);

    state_e          r_state;
    state_e          w_state_next;
    dec_pkt_t        r_main;
    dec_pkt_t        r_skid;
    dec_pkt_t        w_dec;
    logic [XLEN-1:0] w_imm;
    logic [6:0]      w_opcode;
    logic [2:0]      w_funct3;
    logic [6:0]      w_funct7;
    logic            w_accept;
    logic            w_emit;
    logic            w_load_main_in;
    logic            w_load_main_skid;
    logic            w_load_skid;
    logic            w_is_csr;
    logic            w_is_csri;

    assign w_opcode = in_inst[6:0];
    assign w_funct3 = in_inst[14:12];
    assign w_funct7 = in_inst[31:25];

    rip_imm_gen u_imm_gen (
        .i_inst (in_inst),
        .o_imm  (w_imm)
    );

    // Decode the raw word into the one-hot record plus pass-through fields.
    always_comb begin
        w_dec          = '0;
        w_dec.rs1_addr = in_inst[19:15];
        w_dec.rs2_addr = in_inst[24:20];
        w_dec.rd_addr  = in_inst[11:7];
        w_dec.imm      = w_imm;
        w_dec.pc       = in_pc;
        case (w_opcode)
            OPC_LUI:   w_dec.inst.lui   = 1'b1;
            OPC_AUIPC: w_dec.inst.auipc = 1'b1;
            OPC_JAL:   w_dec.inst.jal   = 1'b1;
            OPC_JALR:  w_dec.inst.jalr  = (w_funct3 == 3'd0);
            OPC_BRANCH: begin
                case (w_funct3)
                    3'd0: w_dec.inst.beq  = 1'b1;
                    3'd1: w_dec.inst.bne  = 1'b1;
                    3'd4: w_dec.inst.blt  = 1'b1;
                    3'd5: w_dec.inst.bge  = 1'b1;
                    3'd6: w_dec.inst.bltu = 1'b1;
                    3'd7: w_dec.inst.bgeu = 1'b1;
                    default: ;
                endcase
            end
            OPC_LOAD: begin
                case (w_funct3)
                    3'd0: w_dec.inst.lb  = 1'b1;
                    3'd1: w_dec.inst.lh  = 1'b1;
                    3'd2: w_dec.inst.lw  = 1'b1;
                    3'd4: w_dec.inst.lbu = 1'b1;
                    3'd5: w_dec.inst.lhu = 1'b1;
                    default: ;
                endcase
            end
            OPC_STORE: begin
                case (w_funct3)
                    3'd0: w_dec.inst.sb = 1'b1;
                    3'd1: w_dec.inst.sh = 1'b1;
                    3'd2: w_dec.inst.sw = 1'b1;
                    default: ;
                endcase
            end
            OPC_OP_IMM: begin
                case (w_funct3)
                    3'd0: w_dec.inst.addi  = 1'b1;
                    3'd2: w_dec.inst.slti  = 1'b1;
                    3'd3: w_dec.inst.sltiu = 1'b1;
                    3'd4: w_dec.inst.xori  = 1'b1;
                    3'd6: w_dec.inst.ori   = 1'b1;
                    3'd7: w_dec.inst.andi  = 1'b1;
                    // shamt lives in imm[4:0]; the upper bits act as funct7
                    3'd1: w_dec.inst.slli  = (w_funct7 == F7_BASE);
                    3'd5: begin
                        w_dec.inst.srli = (w_funct7 == F7_BASE);
                        w_dec.inst.srai = (w_funct7 == F7_ALT);
                    end
                    default: ;
                endcase
            end
            OPC_OP: begin
                if (w_funct7 == F7_BASE) begin
                    case (w_funct3)
                        3'd0: w_dec.inst.add    = 1'b1;
                        3'd1: w_dec.inst.sll    = 1'b1;
                        3'd2: w_dec.inst.slt    = 1'b1;
                        3'd3: w_dec.inst.sltu   = 1'b1;
                        3'd4: w_dec.inst.xor_op = 1'b1;
                        3'd5: w_dec.inst.srl    = 1'b1;
                        3'd6: w_dec.inst.or_op  = 1'b1;
                        3'd7: w_dec.inst.and_op = 1'b1;
                        default: ;
                    endcase
                end else if (w_funct7 == F7_ALT) begin
                    w_dec.inst.sub = (w_funct3 == 3'd0);
                    w_dec.inst.sra = (w_funct3 == 3'd5);
                end else if (w_funct7 == F7_MULDIV) begin
                    case (w_funct3)
                        3'd0: w_dec.inst.mul    = 1'b1;
                        3'd1: w_dec.inst.mulh   = 1'b1;
                        3'd2: w_dec.inst.mulhsu = 1'b1;
                        3'd3: w_dec.inst.mulhu  = 1'b1;
                        3'd4: w_dec.inst.div    = 1'b1;
                        3'd5: w_dec.inst.divu   = 1'b1;
                        3'd6: w_dec.inst.rem    = 1'b1;
                        3'd7: w_dec.inst.remu   = 1'b1;
                        default: ;
                    endcase
                end
            end
            OPC_SYSTEM: begin
                case (w_funct3)
                    3'd0: begin
                        w_dec.inst.ecall  = (in_inst == ENC_ECALL);
                        w_dec.inst.ebreak = (in_inst == ENC_EBREAK);
                    end
                    3'd1: w_dec.inst.csrrw  = 1'b1;
                    3'd2: w_dec.inst.csrrs  = 1'b1;
                    3'd3: w_dec.inst.csrrc  = 1'b1;
                    3'd5: w_dec.inst.csrrwi = 1'b1;
                    3'd6: w_dec.inst.csrrsi = 1'b1;
                    3'd7: w_dec.inst.csrrci = 1'b1;
                    default: ;
                endcase
            end
            default: ;
        endcase
        w_is_csri = w_dec.inst.csrrwi | w_dec.inst.csrrsi | w_dec.inst.csrrci;
        w_is_csr  = w_is_csri | w_dec.inst.csrrw | w_dec.inst.csrrs | w_dec.inst.csrrc;
        if (w_is_csr) begin
            w_dec.csr_addr = in_inst[31:20];
        end
        if (w_is_csri) begin
            w_dec.zimm = in_inst[19:15];
        end
        w_dec.illegal = (w_dec.inst == '0);
    end

    // Handshake state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_EMPTY;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next state and buffer load enables; flush overrides every transition.
    always_comb begin
        w_state_next     = r_state;
        w_load_main_in   = 1'b0;
        w_load_main_skid = 1'b0;
        w_load_skid      = 1'b0;
        w_accept         = in_valid & (r_state != ST_FULL);
        w_emit           = (r_state != ST_EMPTY) & out_ready;
        if (flush) begin
            w_state_next = ST_EMPTY;
        end else begin
            case (r_state)
                ST_EMPTY: begin
                    if (w_accept) begin
                        w_state_next   = ST_ONE;
                        w_load_main_in = 1'b1;
                    end
                end
                ST_ONE: begin
                    if (w_accept && w_emit) begin
                        w_load_main_in = 1'b1;
                    end else if (w_accept) begin
                        w_state_next = ST_FULL;
                        w_load_skid  = 1'b1;
                    end else if (w_emit) begin
                        w_state_next = ST_EMPTY;
                    end
                end
                ST_FULL: begin
                    if (w_emit) begin
                        w_state_next     = ST_ONE;
                        w_load_main_skid = 1'b1;
                    end
                end
                default: w_state_next = ST_EMPTY;
            endcase
        end
    end

    // Packet storage: main feeds the outputs, skid absorbs one extra packet.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_main <= '0;
            r_skid <= '0;
        end else begin
            if (w_load_main_in) begin
                r_main <= w_dec;
            end else if (w_load_main_skid) begin
                r_main <= r_skid;
            end
            if (w_load_skid) begin
                r_skid <= w_dec;
            end
        end
    end

    assign in_ready     = (r_state != ST_FULL);
    assign out_valid    = (r_state != ST_EMPTY);
    assign out_inst     = r_main.inst;
    assign out_rs1_addr = r_main.rs1_addr;
    assign out_rs2_addr = r_main.rs2_addr;
    assign out_rd_addr  = r_main.rd_addr;
    assign out_imm      = r_main.imm;
    assign out_zimm     = r_main.zimm;
    assign out_csr_addr = r_main.csr_addr;
    assign out_pc       = r_main.pc;
    assign out_illegal  = r_main.illegal;

endmodule
